// File: rtl/integrator_gain_scheduler.sv
// Gain-walk sequencer for the gyro loop integrator: zero, settle, dwell and step the
// gain shift index from an initial to a final value, then hold lock until told otherwise.
module integrator_gain_scheduler #(
    parameter int unsigned DEF_GAIN   = 5,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned DWELL_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_relock,
    input  logic               i_err_valid,
    input  logic               i_bumpless,
    input  logic [5:0]         i_gain_init,
    input  logic [5:0]         i_gain_final,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [7:0]         i_zero_len,
    output logic [5:0]         o_gain_sel,
    output logic               o_int_en,
    output logic               o_int_zero,
    output logic               o_gain_mode,
    output logic               o_busy,
    output logic               o_locked,
    output logic               o_done,
    output logic [3:0]         o_step_cnt,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ZERO   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_STEP   = 3'd4,
        S_LOCKED = 3'd5
    } state_t;

    localparam logic [5:0] GAIN_MAX = 6'd15;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_latch;

    // Shadow copy of the configuration taken at start; the inputs are ignored afterwards.
    logic [5:0]         r_sh_init;
    logic [5:0]         r_sh_final;
    logic [DWELL_W-1:0] r_sh_dwell;
    logic [7:0]         r_sh_zlen;
    logic               r_sh_bump;

    logic [7:0]         r_phase_cnt;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic [5:0]         r_gain_sel;
    logic               r_int_en;
    logic               r_int_zero;
    logic               r_gain_mode;
    logic               r_busy;
    logic               r_locked;
    logic               r_done;
    logic [3:0]         r_step_cnt;

    logic [7:0]         w_zlen_eff;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_zero_done;
    logic               w_settle_done;
    logic               w_dwell_hit;
    logic               w_enter_zero;
    logic               w_step_exit;
    logic [5:0]         w_gain_stepped;
    logic               w_gain_mode_next;

    function automatic logic [5:0] clamp_gain(input logic [5:0] v);
        return (v > GAIN_MAX) ? GAIN_MAX : v;
    endfunction

    assign w_zlen_eff  = (r_sh_zlen == 8'd0) ? 8'd1 : r_sh_zlen;
    assign w_dwell_eff = (r_sh_dwell == '0) ? DWELL_W'(1) : r_sh_dwell;

    // Compare one bit wider so a full-scale dwell matches before the counter could wrap.
    assign w_zero_done   = ({1'b0, r_phase_cnt} + 9'd1) == {1'b0, w_zlen_eff};
    assign w_settle_done = (r_phase_cnt == SETTLE_LAST);
    assign w_dwell_hit   = i_err_valid &&
                           (({1'b0, r_dwell_cnt} + (DWELL_W + 1)'(1)) == {1'b0, w_dwell_eff});

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next  = S_ZERO;
                    w_latch = 1'b1;
                end
            end
            S_ZERO: begin
                if (w_zero_done) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_settle_done) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_dwell_hit) w_next = (r_gain_sel == r_sh_final) ? S_LOCKED : S_STEP;
            end
            S_STEP: begin
                w_next = S_SETTLE;
            end
            S_LOCKED: begin
                if (i_start) begin
                    w_next  = S_ZERO;
                    w_latch = 1'b1;
                end else if (i_relock) begin
                    w_next = S_ZERO;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (i_abort) begin
            w_next  = S_IDLE;
            w_latch = 1'b0;
        end
    end

    assign w_enter_zero   = (w_next == S_ZERO) && (r_state != S_ZERO);
    assign w_step_exit    = (r_state == S_STEP) && (w_next == S_SETTLE);
    assign w_gain_stepped = (r_sh_final > r_gain_sel) ? r_gain_sel + 6'd1 : r_gain_sel - 6'd1;

    // Bumpless mode covers the step cycle and every settle cycle that follows a step.
    assign w_gain_mode_next = r_sh_bump &&
                              ((w_next == S_STEP) ||
                               ((w_next == S_SETTLE) &&
                                ((r_state == S_STEP) || ((r_state == S_SETTLE) && r_gain_mode))));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sh_init  <= '0;
            r_sh_final <= '0;
            r_sh_dwell <= '0;
            r_sh_zlen  <= '0;
            r_sh_bump  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_sh_init  <= clamp_gain(i_gain_init);
                r_sh_final <= clamp_gain(i_gain_final);
                r_sh_dwell <= i_dwell;
                r_sh_zlen  <= i_zero_len;
                r_sh_bump  <= i_bumpless;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase_cnt <= '0;
            r_dwell_cnt <= '0;
        end else begin
            if (w_next != r_state) begin
                r_phase_cnt <= '0;
            end else if ((r_state == S_ZERO) || (r_state == S_SETTLE)) begin
                r_phase_cnt <= r_phase_cnt + 8'd1;
            end

            if ((w_next == S_RUN) && (r_state != S_RUN)) begin
                r_dwell_cnt <= '0;
            end else if ((r_state == S_RUN) && i_err_valid && !w_dwell_hit) begin
                r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
            end
        end
    end

    // Gain changes only on ZERO entry or as STEP hands over to SETTLE, both with enable low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gain_sel <= 6'(DEF_GAIN);
            r_step_cnt <= '0;
        end else begin
            if (w_enter_zero) begin
                r_gain_sel <= w_latch ? clamp_gain(i_gain_init) : r_sh_init;
                r_step_cnt <= '0;
            end else if (w_step_exit) begin
                r_gain_sel <= w_gain_stepped;
                if (r_step_cnt != 4'd15) r_step_cnt <= r_step_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_int_en    <= 1'b0;
            r_int_zero  <= 1'b0;
            r_gain_mode <= 1'b0;
            r_busy      <= 1'b0;
            r_locked    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_int_en    <= ((w_next == S_RUN) || (w_next == S_LOCKED)) && i_err_valid;
            r_int_zero  <= (w_next == S_ZERO);
            r_gain_mode <= w_gain_mode_next;
            r_busy      <= (w_next == S_ZERO) || (w_next == S_SETTLE) ||
                           (w_next == S_RUN)  || (w_next == S_STEP);
            r_locked    <= (w_next == S_LOCKED);
            r_done      <= (w_next == S_LOCKED) && (r_state != S_LOCKED);
        end
    end

    assign o_gain_sel  = r_gain_sel;
    assign o_int_en    = r_int_en;
    assign o_int_zero  = r_int_zero;
    assign o_gain_mode = r_gain_mode;
    assign o_busy      = r_busy;
    assign o_locked    = r_locked;
    assign o_done      = r_done;
    assign o_step_cnt  = r_step_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_integrator_gain_scheduler.sv
// Scoreboard bench for integrator_gain_scheduler: each scenario queues the expected
// per-cycle output trace alongside its stimulus, then compares cycle by cycle.
module tb_integrator_gain_scheduler;

    localparam int DWELL_W = 16;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_ZERO = 3'd1, ST_SETTLE = 3'd2,
                           ST_RUN = 3'd3, ST_STEP = 3'd4, ST_LOCKED = 3'd5;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_start, i_abort, i_relock, i_err_valid, i_bumpless;
    logic [5:0]         i_gain_init, i_gain_final;
    logic [DWELL_W-1:0] i_dwell;
    logic [7:0]         i_zero_len;
    logic [5:0]         o_gain_sel;
    logic               o_int_en, o_int_zero, o_gain_mode, o_busy, o_locked, o_done;
    logic [3:0]         o_step_cnt;
    logic [2:0]         o_state;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] gain;
        logic       en, zero, mode, busy, locked, done;
        logic [3:0] step;
    } obs_t;

    typedef struct packed {
        logic start, abort, relock, valid;
    } stim_t;

    obs_t  exp_q[$];
    stim_t stim_q[$];
    obs_t  obs, expv;
    stim_t sv;
    int    n_pass = 0;
    int    n_total = 0;

    integrator_gain_scheduler #(.DEF_GAIN(5), .SETTLE_CYC(3), .DWELL_W(DWELL_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_relock(i_relock), .i_err_valid(i_err_valid), .i_bumpless(i_bumpless),
        .i_gain_init(i_gain_init), .i_gain_final(i_gain_final), .i_dwell(i_dwell),
        .i_zero_len(i_zero_len), .o_gain_sel(o_gain_sel), .o_int_en(o_int_en),
        .o_int_zero(o_int_zero), .o_gain_mode(o_gain_mode), .o_busy(o_busy),
        .o_locked(o_locked), .o_done(o_done), .o_step_cnt(o_step_cnt), .o_state(o_state)
    );

    always #5 clk = ~clk;

    assign obs = {o_state, o_gain_sel, o_int_en, o_int_zero, o_gain_mode,
                  o_busy, o_locked, o_done, o_step_cnt};

    task automatic exp_push(input logic [2:0] st, input logic [5:0] g, input logic en,
                            input logic zero, input logic mode, input logic done,
                            input logic [3:0] s);
        obs_t e;
        e.st = st; e.gain = g; e.en = en; e.zero = zero; e.mode = mode;
        e.done = done; e.step = s;
        e.busy = (st >= ST_ZERO) && (st <= ST_STEP);
        e.locked = (st == ST_LOCKED);
        exp_q.push_back(e);
    endtask

    task automatic stim_push(input logic start, input logic abort, input logic relock,
                             input logic valid);
        stim_t s;
        s.start = start; s.abort = abort; s.relock = relock; s.valid = valid;
        stim_q.push_back(s);
    endtask

    task automatic stim_pad(input int n);
        repeat (n) stim_push(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Expected trace of a full acquisition with a valid sample every cycle.
    task automatic gen_acq(input logic [5:0] init, input logic [5:0] fin, input int dwell,
                           input int zlen, input logic bump);
        logic [5:0] g;
        logic [3:0] s;
        g = init;
        s = 4'd0;
        repeat (zlen) exp_push(ST_ZERO, g, 1'b0, 1'b1, 1'b0, 1'b0, s);
        repeat (3) exp_push(ST_SETTLE, g, 1'b0, 1'b0, 1'b0, 1'b0, s);
        forever begin
            repeat (dwell) exp_push(ST_RUN, g, 1'b1, 1'b0, 1'b0, 1'b0, s);
            if (g == fin) break;
            exp_push(ST_STEP, g, 1'b0, 1'b0, bump, 1'b0, s);
            g = (fin > g) ? g + 6'd1 : g - 6'd1;
            if (s != 4'd15) s = s + 4'd1;
            repeat (3) exp_push(ST_SETTLE, g, 1'b0, 1'b0, bump, 1'b0, s);
        end
        exp_push(ST_LOCKED, g, 1'b1, 1'b0, 1'b0, 1'b1, s);
    endtask

    task automatic set_cfg(input logic [5:0] init, input logic [5:0] fin,
                           input logic [DWELL_W-1:0] dwell, input logic [7:0] zlen,
                           input logic bump);
        i_gain_init = init; i_gain_final = fin; i_dwell = dwell;
        i_zero_len = zlen; i_bumpless = bump;
    endtask

    task automatic idle_pulses();
        i_start = 1'b0; i_abort = 1'b0; i_relock = 1'b0; i_err_valid = 1'b1;
        stim_q.delete();
    endtask

    task automatic test_reset();
        obs_t want;
        rst = 1'b1;
        idle_pulses();
        set_cfg(6'd0, 6'd0, '0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        want = '0;
        want.gain = 6'd5;
        n_total++;
        if (obs !== want) $display("FAIL reset_hold: got %h want %h", obs, want);
        else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_total++;
            if (obs !== want) $display("FAIL reset_idle[%0d]: got %h want %h", k, obs, want);
            else n_pass++;
        end
    endtask

    task automatic test_basic_walk();
        set_cfg(6'd3, 6'd6, 16'd4, 8'd2, 1'b0);
        gen_acq(6'd3, 6'd6, 4, 2, 1'b0);
        exp_push(ST_LOCKED, 6'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        exp_push(ST_LOCKED, 6'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL basic_walk[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
    endtask

    // Downward walk with bumpless transfer; a start pulse in SETTLE must be ignored.
    task automatic test_downward_bumpless();
        set_cfg(6'd10, 6'd8, 16'd2, 8'd1, 1'b1);
        gen_acq(6'd10, 6'd8, 2, 1, 1'b1);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        stim_pad(1);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL downward[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
    endtask

    // init == final with zero dwell and zero length, plus gapped valid samples.
    task automatic test_edge_config();
        set_cfg(6'd5, 6'd5, 16'd0, 8'd0, 1'b0);
        exp_push(ST_ZERO, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) exp_push(ST_SETTLE, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) exp_push(ST_RUN, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        exp_push(ST_LOCKED, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        exp_push(ST_LOCKED, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        exp_push(ST_LOCKED, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        exp_push(ST_LOCKED, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        stim_pad(3);
        repeat (3) stim_push(1'b0, 1'b0, 1'b0, 1'b0);
        stim_pad(2);
        stim_push(1'b0, 1'b0, 1'b0, 1'b0);
        stim_pad(1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL edge_cfg[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
    endtask

    // Abort during RUN at gain 4 with a simultaneous start; the start must lose.
    task automatic test_abort();
        set_cfg(6'd3, 6'd6, 16'd4, 8'd2, 1'b0);
        gen_acq(6'd3, 6'd6, 4, 2, 1'b0);
        while (exp_q.size() > 15) void'(exp_q.pop_back());
        repeat (3) exp_push(ST_IDLE, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        stim_pad(14);
        stim_push(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL abort[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
    endtask

    // Relock replays the latched configuration even after the inputs change.
    task automatic test_relock();
        set_cfg(6'd2, 6'd3, 16'd1, 8'd1, 1'b0);
        gen_acq(6'd2, 6'd3, 1, 1, 1'b0);
        repeat (2) exp_push(ST_LOCKED, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL relock_first[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
        set_cfg(6'd9, 6'd0, 16'd7, 8'd4, 1'b1);
        gen_acq(6'd2, 6'd3, 1, 1, 1'b0);
        stim_push(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL relock_again[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
    endtask

    // Asynchronous reset inside the zero pulse, then starts with out-of-range gains.
    task automatic test_reset_midrun_and_clamp();
        set_cfg(6'd7, 6'd7, 16'd1, 8'd5, 1'b0);
        repeat (2) exp_push(ST_ZERO, 6'd7, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL pre_reset[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (o_int_zero !== 1'b0) $display("FAIL rst_zero_drop: got %b want 0", o_int_zero);
        else n_pass++;
        n_total++;
        if (o_gain_sel !== 6'd5) $display("FAIL rst_gain: got %0d want 5", o_gain_sel);
        else n_pass++;
        n_total++;
        if ({o_state, o_busy, o_step_cnt} !== 8'd0)
            $display("FAIL rst_state: got st=%0d busy=%b step=%0d want 0/0/0", o_state, o_busy, o_step_cnt);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        set_cfg(6'd20, 6'd13, 16'd1, 8'd1, 1'b0);
        gen_acq(6'd15, 6'd13, 1, 1, 1'b0);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL clamp_init[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
        set_cfg(6'd13, 6'd40, 16'd1, 8'd1, 1'b0);
        gen_acq(6'd13, 6'd15, 1, 1, 1'b0);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL clamp_final[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
    endtask

    task automatic test_full_scale_dwell();
        set_cfg(6'd1, 6'd1, 16'hFFFF, 8'd1, 1'b0);
        gen_acq(6'd1, 6'd1, 65535, 1, 1'b0);
        stim_push(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (stim_q.size() > 0) sv = stim_q.pop_front(); else sv = 4'b0001;
            {i_start, i_abort, i_relock, i_err_valid} = sv;
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            n_total++;
            if (obs !== expv)
                $display("FAIL full_dwell[%0d]: got st=%0d gain=%0d flags=%b step=%0d want st=%0d gain=%0d flags=%b step=%0d",
                         k, obs.st, obs.gain, {obs.en, obs.zero, obs.mode, obs.busy, obs.locked, obs.done}, obs.step,
                         expv.st, expv.gain, {expv.en, expv.zero, expv.mode, expv.busy, expv.locked, expv.done}, expv.step);
            else n_pass++;
        end
        idle_pulses();
    endtask

    initial begin
        test_reset();
        test_basic_walk();
        test_downward_bumpless();
        test_edge_config();
        test_abort();
        test_relock();
        test_reset_midrun_and_clamp();
        test_full_scale_dwell();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
